// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - four-channel timeout scheduler on one prescaled tick counter and comparator
// Optional feature macro: TIMER_SCHED_PERIODIC_EN (periodic reload of channel deadlines).
module timer_sched #(
   parameter int N_CH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_i,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   output logic [31:0] data_o,
   output logic        int_sig_o
);
   localparam logic INT_ASSERT   = 1'b1;
   localparam logic INT_DEASSERT = 1'b0;

   logic [1:0]      ctrl;
   logic [15:0]     presc;
   logic [15:0]     pcnt;
   logic [31:0]     now;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] arm;
   logic [N_CH-1:0] per;
   logic [31:0]     cmp [N_CH];
   logic [31:0]     dl  [N_CH];
   logic [1:0]      sidx;

   logic [7:0]      off;
   logic            run;
   logic            wr_ctrl;
   logic            wr_presc;
   logic            wr_pend;
   logic [N_CH-1:0] wr_cmp;
   logic [N_CH-1:0] wr_cfg;
   logic [N_CH-1:0] hit_vec;
   logic [31:0]     diff;
   logic            hit;
   logic            bus_owns;
   logic            unused_addr;

   assign off         = addr_i[7:0];
   assign run         = ctrl[0];
   assign unused_addr = ^addr_i[31:8];

   always_comb begin
      wr_ctrl  = we_i && (off == 8'h00);
      wr_presc = we_i && (off == 8'h04);
      wr_pend  = we_i && (off == 8'h0C);
      for (int n = 0; n < N_CH; n++) begin
         wr_cmp[n] = we_i && (off == 8'(16 + 8 * n));
         wr_cfg[n] = we_i && (off == 8'(20 + 8 * n));
      end
   end

   // Single shared comparator: signed difference keeps the test valid across NOW wrap.
   assign diff     = now - dl[sidx];
   assign hit      = run && arm[sidx] && !diff[31];
   assign bus_owns = wr_cmp[sidx] || wr_cfg[sidx];

   always_comb begin
      hit_vec       = '0;
      hit_vec[sidx] = hit;
   end

`ifdef TIMER_SCHED_PERIODIC_EN
   logic [31:0] reload;
   assign reload = dl[sidx] + cmp[sidx];
`else
   assign per = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl  <= '0;
         presc <= '0;
         pcnt  <= '0;
         now   <= '0;
         pend  <= '0;
         arm   <= '0;
         sidx  <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
         per   <= '0;
`endif
         for (int n = 0; n < N_CH; n++) begin
            cmp[n] <= '0;
            dl[n]  <= '0;
         end
      end else begin
         if (wr_ctrl)  ctrl  <= data_i[1:0];
         if (wr_presc) presc <= data_i[15:0];
         if (run) begin
            sidx <= sidx + 2'd1;
            if (pcnt == presc) begin
               pcnt <= '0;
               now  <= now + 32'd1;
            end else begin
               pcnt <= pcnt + 16'd1;
            end
         end else begin
            pcnt <= '0;
         end
         // Scanner set is OR-ed in last so it wins over a simultaneous W1C.
         pend <= (pend & ~(wr_pend ? data_i[N_CH-1:0] : '0)) | hit_vec;
         for (int n = 0; n < N_CH; n++) begin
            if (wr_cmp[n]) cmp[n] <= data_i;
            if (wr_cfg[n]) begin
               arm[n] <= data_i[0];
`ifdef TIMER_SCHED_PERIODIC_EN
               per[n] <= data_i[1];
`endif
               if (data_i[0]) dl[n] <= now + cmp[n];
            end else if (hit_vec[n] && !bus_owns) begin
`ifdef TIMER_SCHED_PERIODIC_EN
               if (per[n]) dl[n] <= reload;
               else        arm[n] <= 1'b0;
`else
               arm[n] <= 1'b0;
`endif
            end
         end
      end
   end

   always_comb begin
      data_o = '0;
      if (!rst) begin
         case (off)
            8'h00:   data_o = {30'd0, ctrl};
            8'h04:   data_o = {16'd0, presc};
            8'h08:   data_o = now;
            8'h0C:   data_o = {{(32 - N_CH){1'b0}}, pend};
            default: begin
               for (int n = 0; n < N_CH; n++) begin
                  if (off == 8'(16 + 8 * n)) data_o = cmp[n];
                  if (off == 8'(20 + 8 * n)) data_o = {29'd0, arm[n], per[n], arm[n]};
               end
            end
         endcase
      end
   end

   assign int_sig_o = (!rst && ctrl[1] && (|pend)) ? INT_ASSERT : INT_DEASSERT;
endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - scoreboard bench for timer_sched against a behavioural register/timer model
module tb_timer_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic [31:0] data_o;
   logic        int_sig_o;

   always #5 clk = ~clk;

   timer_sched #(.N_CH(4)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i),
      .we_i(we_i), .data_o(data_o), .int_sig_o(int_sig_o)
   );

   typedef struct { logic [31:0] exp; logic [31:0] mask; logic irq; string name; } sb_t;
   typedef struct { int act; int lo; int hi; string name; } dc_t;
   sb_t sb[$];
   dc_t dq[$];
   int  checks = 0;
   int  errors = 0;
   logic [31:0] obs;

   // Reference model: architectural state only, advanced once per clock.
   logic [1:0]  m_ctrl;
   logic [15:0] m_presc;
   int          m_pcnt;
   int          m_sidx;
   logic [31:0] m_now;
   logic [3:0]  m_pend, m_arm, m_per;
   logic [31:0] m_cmp [4];
   logic [31:0] m_dl  [4];

   function automatic void m_reset();
      m_ctrl = 0; m_presc = 0; m_pcnt = 0; m_sidx = 0; m_now = 0;
      m_pend = 0; m_arm = 0; m_per = 0;
      for (int n = 0; n < 4; n++) begin m_cmp[n] = 0; m_dl[n] = 0; end
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int n;
      if (rst) return 32'd0;
      if (a == 8'h00) return {30'd0, m_ctrl};
      if (a == 8'h04) return {16'd0, m_presc};
      if (a == 8'h08) return m_now;
      if (a == 8'h0C) return {28'd0, m_pend};
      if (a >= 8'h10 && a < 8'h30 && a[1:0] == 2'b00) begin
         n = (int'(a) - 16) / 8;
         if (a[2] == 1'b0) return m_cmp[n];
         return {29'd0, m_arm[n], m_per[n], m_arm[n]};
      end
      return 32'd0;
   endfunction

   function automatic logic m_irq();
      return !rst && m_ctrl[1] && (m_pend != 4'd0);
   endfunction

   function automatic bit m_expiring();
      return m_ctrl[0] && m_arm[m_sidx] && (int'(m_now - m_dl[m_sidx]) >= 0);
   endfunction

   function automatic void m_step(input bit we, input logic [7:0] a, input logic [31:0] d);
      bit          run    = m_ctrl[0];
      int          ch     = m_sidx;
      bit          fire   = m_expiring();
      bit          owned  = 0;
      logic [31:0] now0   = m_now;
      logic [15:0] presc0 = m_presc;
      if (we) begin
         if (a == 8'h00) m_ctrl = d[1:0];
         if (a == 8'h04) m_presc = d[15:0];
         if (a == 8'h0C) m_pend = m_pend & ~d[3:0];
         for (int n = 0; n < 4; n++) begin
            if (a == 8'(16 + 8 * n)) begin
               m_cmp[n] = d;
               owned |= (n == ch);
            end
            if (a == 8'(20 + 8 * n)) begin
               m_arm[n] = d[0];
`ifdef TIMER_SCHED_PERIODIC_EN
               m_per[n] = d[1];
`endif
               if (d[0]) m_dl[n] = now0 + m_cmp[n];
               owned |= (n == ch);
            end
         end
      end
      if (fire) begin
         m_pend[ch] = 1'b1;
         if (!owned) begin
            if (m_per[ch]) m_dl[ch] = m_dl[ch] + m_cmp[ch];
            else           m_arm[ch] = 1'b0;
         end
      end
      if (run) begin
         m_sidx = (m_sidx + 1) % 4;
         if (m_pcnt == int'(presc0)) begin
            m_pcnt = 0;
            m_now  = m_now + 32'd1;
         end else begin
            m_pcnt = m_pcnt + 1;
         end
      end else begin
         m_pcnt = 0;
      end
   endfunction

   task automatic cyc(input bit r, input bit we, input logic [7:0] a, input logic [31:0] d,
                      input bit use_k, input logic [31:0] k, input logic [31:0] mk,
                      input int irq_k, input string nm);
      sb_t e;
      rst    = r;
      we_i   = we;
      addr_i = {24'($urandom()), a};
      data_i = d;
      e.exp  = use_k ? k : m_read(a);
      e.mask = use_k ? mk : 32'hFFFF_FFFF;
      e.irq  = (irq_k < 0) ? m_irq() : irq_k[0];
      e.name = nm;
      sb.push_back(e);
      @(negedge clk);
      obs = data_o;
      @(posedge clk);
      if (r) m_reset();
      else   m_step(we, a, d);
      #1;
   endtask

   task automatic rd(input logic [7:0] a);
      cyc(0, 0, a, $urandom(), 0, 0, 0, -1, $sformatf("read_%02h", a));
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      cyc(0, 1, a, d, 0, 0, 0, -1, $sformatf("write_%02h", a));
   endtask

   task automatic rdk(input logic [7:0] a, input logic [31:0] k, input logic [31:0] mk,
                      input int irq_k, input string nm);
      cyc(0, 0, a, 0, 1, k, mk, irq_k, nm);
   endtask

   task automatic dchk(input string nm, input int act, input int lo, input int hi);
      dc_t c;
      c.act = act; c.lo = lo; c.hi = hi; c.name = nm;
      dq.push_back(c);
   endtask

   always @(negedge clk) begin : monitor
      sb_t e;
      dc_t c;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if ((data_o & e.mask) !== (e.exp & e.mask)) begin
            errors++;
            $display("FAIL %s data_o: got %h, required %h", e.name, data_o & e.mask, e.exp & e.mask);
         end
         checks++;
         if (int_sig_o !== e.irq) begin
            errors++;
            $display("FAIL %s int_sig_o: got %b, required %b", e.name, int_sig_o, e.irq);
         end
      end
      while (dq.size() > 0) begin
         c = dq.pop_front();
         checks++;
         if (c.act < c.lo || c.act > c.hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", c.name, c.act, c.lo, c.hi);
         end
      end
   end

   initial begin
      int found;
      int hitc;
      rst = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0;
      m_reset();
      @(posedge clk); #1;

      // Reset state and unmapped/read-only behaviour
      repeat (3) cyc(1, 0, 8'($urandom()), $urandom(), 0, 0, 0, -1, "in_reset");
      for (int o = 0; o < 64; o += 4) rdk(8'(o), 32'd0, 32'hFFFF_FFFF, 0, "reset_value");
      rdk(8'hFF, 32'd0, 32'hFFFF_FFFF, 0, "unmapped");
      wr(8'h08, 32'h1234);
      rdk(8'h08, 32'd0, 32'hFFFF_FFFF, 0, "now_ro");

      // Prescaler: 40 run clocks at PRESC=3 give 10 ticks, then freeze
      wr(8'h04, 3);
      wr(8'h00, 1);
      repeat (40) rd(8'h08);
      rdk(8'h08, 32'd10, 32'hFFFF_FFFF, 0, "now_after_40");
      wr(8'h00, 0);
      rdk(8'h08, 32'd10, 32'hFFFF_FFFF, 0, "now_frozen");
      rdk(8'h08, 32'd10, 32'hFFFF_FFFF, 0, "now_frozen2");
      dchk("pcnt_cleared", int'(dut.pcnt), 0, 0);

      // One-shot expiry and interrupt
      wr(8'h04, 0);
      wr(8'h10, 20);
      wr(8'h14, 1);
      wr(8'h00, 3);
      for (int i = 0; i < 40; i++) begin
         if (m_pend[0]) break;
         rd(8'h0C);
      end
      rdk(8'h0C, 32'h1, 32'h1, 1, "pend0_irq");
      wr(8'h0C, 1);
      rdk(8'h0C, 32'h0, 32'h1, 0, "pend0_cleared");
      rdk(8'h14, 32'h0, 32'h1, 0, "cfg0_disarmed");
      wr(8'h00, 1);

`ifdef TIMER_SCHED_PERIODIC_EN
      begin : periodic_test
         int  rises[$];
         bit  prev;
         bit  clr;
         prev = 0; clr = 0;
         wr(8'h20, 8);
         wr(8'h24, 3);
         for (int i = 0; i < 110; i++) begin
            if (clr) wr(8'h0C, 4);
            else     rd(8'h0C);
            clr = obs[2];
            if (obs[2] && !prev) rises.push_back(i);
            prev = obs[2];
         end
         dchk("periodic_count", rises.size(), 11, 1000);
         for (int k = 1; k <= 10; k++)
            if (k < rises.size())
               dchk($sformatf("periodic_phase_%0d", k), rises[k] - rises[0], 8 * k - 3, 8 * k + 3);
      end
`else
      wr(8'h20, 8);
      wr(8'h24, 3);
      rdk(8'h24, 32'h5, 32'h7, -1, "cfg2_no_periodic");
      repeat (20) rd(8'h0C);
      rdk(8'h24, 32'h0, 32'h7, -1, "cfg2_oneshot_done");
`endif
      wr(8'h24, 0);
      wr(8'h0C, 4);

      // Wrap-safe compare: deadline lands past the NOW wrap
      wr(8'h00, 0);
      force dut.now = 32'hFFFF_FFF8;
      m_now = 32'hFFFF_FFF8;
      rd(8'h08);
      release dut.now;
      rdk(8'h08, 32'hFFFF_FFF8, 32'hFFFF_FFFF, -1, "now_preload");
      wr(8'h18, 16);
      wr(8'h1C, 1);
      wr(8'h00, 1);
      found = -1;
      for (int i = 0; i < 40; i++) begin
         rd(8'h0C);
         if (obs[1]) begin found = i; break; end
      end
      dchk("wrap_latency", found, 17, 20);

      // W1C landing on the same clock as a channel-1 expiry
      wr(8'h0C, 2);
      wr(8'h18, 5);
      wr(8'h1C, 1);
      hitc = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_expiring() && m_sidx == 1) begin
            wr(8'h0C, 2);
            hitc = 1;
            break;
         end
         rd(8'h0C);
      end
      dchk("w1c_collision_reached", hitc, 1, 1);
      rdk(8'h0C, 32'h2, 32'h2, -1, "set_beats_w1c");

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         int op;
         int ch;
         op = $urandom_range(0, 99);
         ch = $urandom_range(0, 3);
         if (op < 1) begin
            cyc(1, 0, 8'($urandom()), $urandom(), 0, 0, 0, -1, "rand_reset");
         end else if (op < 45) begin
            if ($urandom_range(0, 3) == 0) rd(8'($urandom()));
            else                           rd(8'(4 * $urandom_range(0, 11)));
         end else begin
            case ($urandom_range(0, 7))
               0: wr(8'h00, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
               1: wr(8'h04, $urandom_range(0, 2));
               2: wr(8'h08, $urandom());
               3: wr(8'h0C, $urandom());
               4, 5: wr(8'(16 + 8 * ch), $urandom_range(0, 24));
               default: wr(8'(20 + 8 * ch), $urandom_range(0, 7));
            endcase
         end
      end

      rd(8'h0C);
      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/timer_sched.md
# timer_sched

Four-channel timeout scheduler that shares one prescaled free-running tick counter and one wrap-safe comparator among four software-programmable channels. It sits on the peripheral bus next to the single-shot timer and uses the same register-mapped slave interface: combinational read, single-cycle write. Pending expiries from all channels merge into one interrupt line toward the core's interrupt controller.

## Interface
- `N_CH`, 4: number of channels; fixed at 4, since the address map below assumes 4.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_i` input 32: write data.
- `addr_i` input 32: byte address; only `addr_i[7:0]` is decoded.
- `we_i` input 1: write enable (`WriteEnable`), single cycle.
- `data_o` output 32: combinational read data; 0 while `rst` is high or for unmapped offsets.
- `int_sig_o` output 1: `INT_ASSERT` when `CTRL[1]` is set and `PEND` is nonzero; otherwise `INT_DEASSERT`.

## Operation
Register map (offsets):
- 0x00 `CTRL`, RW.
  - [0] run: global enable.
  - [1] int enable.
  - Other bits read 0.
- 0x04 `PRESC`, RW, 16 bits: one tick every `PRESC`+1 clocks.
- 0x08 `NOW`, RO, 32-bit tick count. Writes are ignored.
- 0x0C `PEND`, [3:0] one bit per channel. Write-1-to-clear; writing 0 leaves the bit unchanged.
- 0x10+8n `CMPn`, RW, 32 bits: interval in ticks.
- 0x14+8n `CFGn`, RW.
  - [0] arm.
  - [1] periodic.
  - Reads also return internal `DLn` (deadline) status: [2] reads 1 while armed.

Behaviour:
- Prescaler: `pcnt` increments each clock while run=1. When `pcnt == PRESC`, `pcnt` returns to 0 and `NOW` increments by 1. `NOW` wraps modulo 2^32.
- Run=0: `pcnt` clears to 0, and `NOW`, the scanner and all deadlines freeze. Arm flags and `PEND` keep their values.
- Arming: a write to `CFGn` with [0]=1 loads `DLn <= NOW + CMPn`, using `NOW` as it was in the write cycle. Adds are 32-bit and wrapping. A write with [0]=0 disarms channel n; `DLn` keeps its value.
- Scanner:
  - A 2-bit index `sidx` advances by 1 each clock while run=1, in the order 0,1,2,3,0…
  - The selected channel has expired when it is armed and `(NOW - DLn)` is ≥ 0 as a signed 32-bit value. This comparison is wrap-safe for intervals below 2^31.
  - On expiry: `PEND[sidx]` is set. If periodic, `DLn <= DLn + CMPn`. Otherwise the channel is disarmed.
- Conflicts in the same cycle:
  - Scanner expiry and a W1C on the same `PEND` bit: the set wins.
  - Scanner expiry and a bus write to `CFGn` or `CMPn` of the same channel: the bus write wins for arm and `DLn`, and `PEND` is still set.
- `CMPn` = 0 with arm: the channel expires at its first scan slot. If periodic, it re-expires every 4 clocks.

## Timing
- Reset: every register, `pcnt`, `sidx`, all `DLn` and all arm flags go to 0. `data_o` = 0 and `int_sig_o` deasserts in the same cycle as reset.
- Write effects are visible on read the cycle after `we_i`.
- Expiry latency: from the clock edge where `NOW` reaches `DLn` to `PEND` set is 1 to `N_CH` clocks, depending on scan position.
- `int_sig_o` is combinational from `PEND` and `CTRL`, so it rises in the cycle after `PEND` is set. It falls in the cycle after a W1C clears the last pending bit.
- Reset during any state aborts it in one cycle. There is no partial state.

## Configuration
- `TIMER_SCHED_PERIODIC_EN` defined: `CFGn[1]` is stored, and periodic reload works as described in Operation.
- `TIMER_SCHED_PERIODIC_EN` undefined:
  - `CFGn[1]` is not stored and reads 0.
  - Writes to `CFGn[1]` are ignored.
  - Every expiry disarms the channel (one-shot only).
  - The deadline reload adder is absent.

## Test plan
- Reset, then read all offsets: every register reads 0 and `int_sig_o`=0. Write `NOW`=0x1234, then read it back: still 0.
- `PRESC`=3, `CTRL`=1, wait 40 clocks: `NOW`=10. Clear run: `NOW` holds at 10 and `pcnt` is 0.
- `PRESC`=0, `CMP0`=20, `CFG0`=1, `CTRL`=3: `PEND`=0x1 within 24 clocks of arming and `int_sig_o`=1. W1C 0x1 clears the interrupt, and `CFG0[0]`=0.
- With the macro defined: `CMP2`=8, `CFG2`=3, `CTRL`=1. `PEND[2]` sets every 8 ticks, with jitter ≤ 3 clocks and no drift over 10 periods.
- Force `NOW` near wrap by running from reset with `PRESC`=0 through 0xFFFFFFF8 (backdoor preload allowed). Arm `CMP1`=16: expiry occurs after `NOW` wraps to 8, not immediately.
- Time a W1C of `PEND[1]` to coincide with a channel-1 expiry: `PEND[1]` reads 1 afterward.
